// File: rtl/key_cam_if.sv
// key_cam_if: bus bundle for the key_cam associative store.
//
// Handshake rule (all three channels): a transfer happens on a rising clock
// edge where the sender's valid and the receiver's ready are both high; a
// sender keeps its payload stable while valid is high and ready is low.
//
// Signals:
//   flush                         one-cycle invalidate-all pulse
//   wr_valid/wr_ready/wr_key/wr_data   insert or update of a (key, data) pair
//   req_valid/req_ready/req_key        lookup request
//   resp_valid/resp_ready/resp_hit/resp_data   registered lookup result
//   count, full                   occupancy status
// Modports: master = producer/consumer side, slave = key_cam side.
interface key_cam_if #(
  parameter int NR_ENTRY = 4,
  parameter int KEY_LEN  = 8,
  parameter int DATA_LEN = 32
);
  localparam int CNT_W = $clog2(NR_ENTRY + 1);

  logic                flush;
  logic                wr_valid;
  logic                wr_ready;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic                req_valid;
  logic                req_ready;
  logic [KEY_LEN-1:0]  req_key;
  logic                resp_valid;
  logic                resp_ready;
  logic                resp_hit;
  logic [DATA_LEN-1:0] resp_data;
  logic [CNT_W-1:0]    count;
  logic                full;

  modport master (
    output flush, wr_valid, wr_key, wr_data, req_valid, req_key, resp_ready,
    input  wr_ready, req_ready, resp_valid, resp_hit, resp_data, count, full
  );

  modport slave (
    input  flush, wr_valid, wr_key, wr_data, req_valid, req_key, resp_ready,
    output wr_ready, req_ready, resp_valid, resp_hit, resp_data, count, full
  );
endinterface

// File: rtl/key_cam.sv
// key_cam: small associative key->data store with runtime insertion.
//
// Writes insert a new pair, update the data of a key already present, or,
// when the table is full, replace entries in round-robin order. Lookups
// return a registered hit flag and data one cycle after acceptance.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - key_cam_if slave modport (write, lookup, response, status)
//
// Optional feature macro: KEY_CAM_BYPASS_EN
//   defined   : a lookup accepted together with an accepted write of the same
//               key returns the data being written.
//   undefined : lookups always see the table as it was before the edge.
module key_cam #(
  parameter int NR_ENTRY = 4,
  parameter int KEY_LEN  = 8,
  parameter int DATA_LEN = 32
) (
  input logic     clk,
  input logic     rst,
  key_cam_if.slave bus
);
  localparam int IDX_W = $clog2(NR_ENTRY);
  localparam int CNT_W = $clog2(NR_ENTRY + 1);

  logic [NR_ENTRY-1:0] valid_q, valid_d;
  logic [KEY_LEN-1:0]  key_q  [NR_ENTRY];
  logic [KEY_LEN-1:0]  key_d  [NR_ENTRY];
  logic [DATA_LEN-1:0] data_q [NR_ENTRY];
  logic [DATA_LEN-1:0] data_d [NR_ENTRY];
  logic [IDX_W-1:0]    victim_q, victim_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [DATA_LEN-1:0] resp_data_q, resp_data_d;

  logic                req_ready;
  logic                wr_fire;
  logic                req_fire;
  logic                wr_match;
  logic [IDX_W-1:0]    wr_match_idx;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic                lk_hit;
  logic [DATA_LEN-1:0] lk_data;

  assign req_ready = !resp_valid_q || bus.resp_ready;
  assign wr_fire   = bus.wr_valid && !bus.flush;
  assign req_fire  = bus.req_valid && req_ready;

  // Searches against the registered table. Scanning from the top index down
  // lets the last assignment win, so free_idx ends up the lowest free slot.
  always_comb begin
    wr_match     = 1'b0;
    wr_match_idx = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    lk_hit       = 1'b0;
    lk_data      = '0;
    for (int i = NR_ENTRY - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == bus.wr_key) begin
        wr_match     = 1'b1;
        wr_match_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid_q[i] && key_q[i] == bus.req_key) begin
        lk_hit  = 1'b1;
        lk_data = data_q[i];
      end
    end
  end

  // Table next state. flush and an accepted write never coincide because
  // wr_ready is low during flush.
  always_comb begin
    valid_d  = valid_q;
    key_d    = key_q;
    data_d   = data_q;
    victim_d = victim_q;
    count_d  = count_q;
    if (bus.flush) begin
      valid_d  = '0;
      victim_d = '0;
      count_d  = '0;
    end else if (wr_fire) begin
      if (wr_match) begin
        data_d[wr_match_idx] = bus.wr_data;
      end else if (free_found) begin
        valid_d[free_idx] = 1'b1;
        key_d[free_idx]   = bus.wr_key;
        data_d[free_idx]  = bus.wr_data;
        count_d           = count_q + CNT_W'(1);
      end else begin
        key_d[victim_q]  = bus.wr_key;
        data_d[victim_q] = bus.wr_data;
        victim_d = (victim_q == IDX_W'(NR_ENTRY - 1)) ? '0 : victim_q + IDX_W'(1);
      end
    end
  end

  // Response register: loads on accept, otherwise drops valid once consumed
  // and holds hit/data stable under backpressure.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_data_d  = resp_data_q;
    if (req_fire) begin
      resp_valid_d = 1'b1;
      resp_hit_d   = lk_hit;
      resp_data_d  = lk_data;
`ifdef KEY_CAM_BYPASS_EN
      if (wr_fire && bus.wr_key == bus.req_key) begin
        resp_hit_d  = 1'b1;
        resp_data_d = bus.wr_data;
      end
`endif
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      victim_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < NR_ENTRY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      key_q        <= key_d;
      data_q       <= data_d;
      victim_q     <= victim_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.wr_ready   = !bus.flush;
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.count      = count_q;
  assign bus.full       = (count_q == CNT_W'(NR_ENTRY));
endmodule
